// File: rtl/ram_arbiter.sv
// Two-master arbiter for a synchronous-read word RAM: m0 has fixed priority,
// m1 gets an anti-starvation boost and can lock the RAM for multi-beat transfers.
module ram_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_wa,
  output logic [ADDR_W-1:0] ram_ra,
  output logic [DATA_W-1:0] ram_wd,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_out
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  typedef enum logic {
    ST_ARB,
    ST_LOCK1
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic               r_m0_rvalid;
  logic               r_m1_rvalid;

  logic               w_m1_pri;
  logic               w_m0_gnt;
  logic               w_m1_gnt;
  logic [ADDR_W-1:0]  w_addr;

  assign w_m1_pri = m1_req && (r_wait_cnt == MAX_CNT);

  // A locked m1 that drops its request releases the RAM in the same cycle,
  // so m0 may be served immediately rather than losing a cycle.
  always_comb begin
    w_m0_gnt = 1'b0;
    w_m1_gnt = 1'b0;
    if (reset_n) begin
      case (r_state)
        ST_ARB: begin
          if (w_m1_pri)    w_m1_gnt = 1'b1;
          else if (m0_req) w_m0_gnt = 1'b1;
          else if (m1_req) w_m1_gnt = 1'b1;
        end
        ST_LOCK1: begin
          if (m1_req)      w_m1_gnt = 1'b1;
          else if (m0_req) w_m0_gnt = 1'b1;
        end
        default: begin
          w_m0_gnt = 1'b0;
          w_m1_gnt = 1'b0;
        end
      endcase
    end
  end

  assign w_addr = w_m1_gnt ? m1_addr : m0_addr;

  assign m0_gnt    = w_m0_gnt;
  assign m1_gnt    = w_m1_gnt;
  assign ram_wa    = w_addr;
  assign ram_ra    = w_addr;
  assign ram_wd    = w_m1_gnt ? m1_wdata : m0_wdata;
  assign ram_we    = (w_m0_gnt & m0_we) | (w_m1_gnt & m1_we);
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = ram_out;
  assign m1_rdata  = ram_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_ARB;
      r_wait_cnt  <= '0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
    end else begin
      r_m0_rvalid <= w_m0_gnt & ~m0_we;
      r_m1_rvalid <= w_m1_gnt & ~m1_we;

      if (w_m1_gnt)
        r_wait_cnt <= '0;
      else if (m1_req && (r_wait_cnt != MAX_CNT))
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);

      case (r_state)
        ST_ARB:   if (w_m1_gnt && m1_lock) r_state <= ST_LOCK1;
        ST_LOCK1: if (!m1_req || !m1_lock) r_state <= ST_ARB;
        default:  r_state <= ST_ARB;
      endcase
    end
  end

endmodule
